// File: rtl/mem_arb_pkg.sv
// Shared types and block-geometry constants for the memory fill arbiter.
package mem_arb_pkg;

    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_W        = 3;

    typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;
    typedef enum logic [1:0] {NONE, OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/fill_seq_counter.sv
// Word counter for one side of a block fill (issue or receive).
// Wraps to zero after the last word and raises done until the next clear.
module fill_seq_counter
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    output logic [WORD_IDX_W-1:0] count,
    output logic                  done
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (inc && !done) begin
            count <= count + 1'b1;
            if (count == '1)
                done <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Sole owner of main memory: grants D stores, D fills and I fills in fixed
// priority and steers returned block words into the owning cache.
module mem_fill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss,
    input  logic [ADDR_W-1:0]     i_miss_addr,
    input  logic                  d_miss,
    input  logic [ADDR_W-1:0]     d_miss_addr,
    input  logic                  d_wr_req,
    input  logic [ADDR_W-1:0]     d_wr_addr,
    input  logic [15:0]           d_wr_data,
    output logic                  d_wr_ack,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic                  mem_data_valid,
    input  logic [15:0]           mem_data_out,
    output logic [15:0]           fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  i_busy,
    output logic                  d_busy,
    output logic                  i_write_data_array,
    output logic                  d_write_data_array,
    output logic                  i_write_tag_array,
    output logic                  d_write_tag_array
);

    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);

    state_t                state, state_nx;
    owner_t                owner;
    logic [ADDR_W-1:0]     base;
    logic [WORD_IDX_W-1:0] iss_cnt, rx_cnt;
    logic                  iss_done, rx_done;
    logic                  enter_fill, rx_strobe, rx_last;

    assign enter_fill = (state == IDLE) && !d_wr_req && (d_miss || i_miss);
    assign rx_strobe  = (state == FILL) && mem_data_valid && !rx_done;
    assign rx_last    = rx_strobe && (rx_cnt == '1);

    fill_seq_counter u_iss (
        .clk   (clk),
        .rst   (rst),
        .clear (enter_fill),
        .inc   ((state == FILL) && !iss_done),
        .count (iss_cnt),
        .done  (iss_done)
    );

    fill_seq_counter u_rx (
        .clk   (clk),
        .rst   (rst),
        .clear (enter_fill),
        .inc   (rx_strobe),
        .count (rx_cnt),
        .done  (rx_done)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // D miss outranks I miss when both are pending at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= NONE;
            base  <= '0;
        end else if (enter_fill) begin
            owner <= d_miss ? OWN_D : OWN_I;
            base  <= (d_miss ? d_miss_addr : i_miss_addr) & BLK_MASK;
        end else if (rx_last) begin
            owner <= NONE;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (d_wr_req)             state_nx = WRITE;
                     else if (d_miss || i_miss) state_nx = FILL;
            WRITE:   state_nx = IDLE;
            FILL:    if (rx_last)              state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        d_wr_ack           = 1'b0;
        mem_enable         = 1'b0;
        mem_wr             = 1'b0;
        mem_addr           = '0;
        mem_data_in        = '0;
        fill_data          = '0;
        fill_word          = rx_cnt;
        i_busy             = 1'b0;
        d_busy             = 1'b0;
        i_write_data_array = 1'b0;
        d_write_data_array = 1'b0;
        i_write_tag_array  = 1'b0;
        d_write_tag_array  = 1'b0;
        unique case (state)
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_wr_addr;
                mem_data_in = d_wr_data;
                d_wr_ack    = 1'b1;
            end
            FILL: begin
                mem_enable = !iss_done;
                if (!iss_done)
                    mem_addr = base + ADDR_W'({iss_cnt, 1'b0});
                fill_data = mem_data_out;
                if (owner == OWN_D) begin
                    d_busy             = 1'b1;
                    d_write_data_array = rx_strobe;
                    d_write_tag_array  = rx_last;
                end else if (owner == OWN_I) begin
                    i_busy             = 1'b1;
                    i_write_data_array = rx_strobe;
                    i_write_tag_array  = rx_last;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench: latency-4 memory model, cycle-level reference model of the
// arbiter's rules, plus literal expectations for each scenario.
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst, i_miss, d_miss, d_wr_req, mem_data_valid;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data, mem_data_out;
    logic        d_wr_ack, mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in, fill_data;
    logic [2:0]  fill_word;
    logic        i_busy, d_busy, i_write_data_array, d_write_data_array;
    logic        i_write_tag_array, d_write_tag_array;

    always #5 clk = ~clk;

    mem_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .d_wr_ack(d_wr_ack),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .mem_data_out(mem_data_out),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_busy(i_busy), .d_busy(d_busy),
        .i_write_data_array(i_write_data_array), .d_write_data_array(d_write_data_array),
        .i_write_tag_array(i_write_tag_array), .d_write_tag_array(d_write_tag_array)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] md(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Memory: each read returns md(addr) four cycles after issue, in order.
    typedef struct {logic [15:0] a; int due;} req_t;
    req_t mq[$];
    int   cyc = 0;
    int   delivered = 0;
    int   stall_at = -1;
    int   stall_left = 0;
    int   spur_at = -1;

    initial begin
        mem_data_valid = 1'b0;
        mem_data_out   = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_data_valid = 1'b0;
            if (cyc == spur_at) begin
                mem_data_valid = 1'b1;
                mem_data_out   = 16'hDEAD;
            end else if (stall_left > 0) begin
                stall_left--;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                mem_data_valid = 1'b1;
                mem_data_out   = md(mq[0].a);
                void'(mq.pop_front());
                delivered++;
                if (delivered == stall_at)
                    stall_left = 2;
            end
            @(negedge clk);
            if (mem_enable && !mem_wr)
                mq.push_back('{mem_addr, cyc + 4});
        end
    end

    // Reference model state: mode 0 idle, 1 store, 2 fill.
    bit          chk_en = 1'b0;
    int          m_mode = 0;
    bit          m_d = 1'b0;
    logic [15:0] m_blk = 16'h0;
    int          m_iss = 0, m_rcv = 0;
    logic        e_en, e_wr, e_ack, e_ib, e_db, e_iw, e_dw, e_it, e_dt;
    logic [15:0] e_addr, e_din;
    int          e_fw;

    // Observation logs for the literal checks.
    int          clr_req = 0, clr_seen = 0;
    logic [15:0] rd_log[$];
    int busy_d, busy_i, fb_d, fb_i, fwd_d, tag_d, ack_cnt, ack_cyc, wd_d, wd_i, first_fw;
    logic [15:0] wr_addr, wr_data;

    always @(negedge clk) begin
        if (chk_en) begin
            {e_en, e_wr, e_ack, e_ib, e_db, e_iw, e_dw, e_it, e_dt} = '0;
            e_addr = 16'h0;
            e_din  = 16'h0;
            e_fw   = 0;
            if (m_mode == 1) begin
                {e_en, e_wr, e_ack} = 3'b111;
                e_addr = d_wr_addr;
                e_din  = d_wr_data;
            end else if (m_mode == 2) begin
                e_fw = m_rcv % 8;
                if (m_d) e_db = 1'b1; else e_ib = 1'b1;
                if (m_iss < 8) begin
                    e_en   = 1'b1;
                    e_addr = m_blk + 16'(2 * m_iss);
                end
                if (mem_data_valid) begin
                    if (m_d) begin e_dw = 1'b1; e_dt = (m_rcv == 7); end
                    else     begin e_iw = 1'b1; e_it = (m_rcv == 7); end
                end
            end
            chk("mem_enable", mem_enable, e_en);
            chk("mem_wr", mem_wr, e_wr);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_data_in", mem_data_in, e_din);
            chk("d_wr_ack", d_wr_ack, e_ack);
            chk("i_busy", i_busy, e_ib);
            chk("d_busy", d_busy, e_db);
            chk("i_write_data", i_write_data_array, e_iw);
            chk("d_write_data", d_write_data_array, e_dw);
            chk("i_write_tag", i_write_tag_array, e_it);
            chk("d_write_tag", d_write_tag_array, e_dt);
            chk("fill_word", fill_word, e_fw);
            if (e_iw || e_dw)
                chk("fill_data", fill_data, md(m_blk + 16'(2 * m_rcv)));

            if (rst) begin
                m_mode = 0; m_iss = 0; m_rcv = 0;
            end else if (m_mode == 0) begin
                m_iss = 0; m_rcv = 0;
                if (d_wr_req)    m_mode = 1;
                else if (d_miss) begin m_mode = 2; m_d = 1'b1; m_blk = d_miss_addr & 16'hFFF0; end
                else if (i_miss) begin m_mode = 2; m_d = 1'b0; m_blk = i_miss_addr & 16'hFFF0; end
            end else if (m_mode == 1) begin
                m_mode = 0;
            end else begin
                if (m_iss < 8) m_iss++;
                if (mem_data_valid) m_rcv++;
                if (m_rcv == 8) m_mode = 0;
            end
        end

        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            rd_log.delete();
            busy_d = 0; busy_i = 0; fb_d = -1; fb_i = -1; fwd_d = -1; tag_d = -1;
            ack_cnt = 0; ack_cyc = -1; wd_d = 0; wd_i = 0; first_fw = -1;
            wr_addr = 16'h0; wr_data = 16'h0;
        end
        if (d_busy) begin busy_d++; if (fb_d < 0) fb_d = cyc; end
        if (i_busy) begin busy_i++; if (fb_i < 0) fb_i = cyc; end
        if (mem_enable && !mem_wr) rd_log.push_back(mem_addr);
        if (mem_enable && mem_wr) begin wr_addr = mem_addr; wr_data = mem_data_in; end
        if (d_wr_ack) begin ack_cnt++; ack_cyc = cyc; end
        if (d_write_data_array) begin wd_d++; if (fwd_d < 0) fwd_d = cyc; end
        if (i_write_data_array) wd_i++;
        if ((d_write_data_array || i_write_data_array) && first_fw < 0) first_fw = int'(fill_word);
        if (d_write_tag_array) tag_d = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        clr_req++;
    endtask

    // sel: 0 d tag, 1 i tag, 2 store ack, 3 D word 4 written
    task automatic wait_ev(input int sel, input string nm);
        bit hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            case (sel)
                0:       hit = d_write_tag_array;
                1:       hit = i_write_tag_array;
                2:       hit = d_wr_ack;
                default: hit = d_write_data_array && (fill_word == 3'd4);
            endcase
        end
        chk({"wait_", nm}, hit, 1);
    endtask

    initial begin
        rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_mem_enable", mem_enable, 0);
        chk("rst_d_busy", d_busy, 0);
        chk("rst_fill_word", fill_word, 0);
        tick();
        rst = 1'b0;

        // 1: single D miss, nominal latency
        clear_logs();
        d_miss = 1'b1; d_miss_addr = 16'h1236;
        wait_ev(0, "t1_tag");
        tick(); d_miss = 1'b0;
        tick(); tick();
        chk("t1_reads", rd_log.size(), 8);
        chk("t1_first_addr", rd_log[0], 16'h1230);
        chk("t1_last_addr", rd_log[7], 16'h123E);
        chk("t1_busy_cycles", busy_d, 12);
        chk("t1_words", wd_d, 8);
        chk("t1_first_data_lat", fwd_d - fb_d, 4);
        chk("t1_tag_cycle", tag_d - fb_d, 11);
        chk("t1_i_busy", busy_i, 0);

        // 2: simultaneous misses, D first
        clear_logs();
        d_miss = 1'b1; d_miss_addr = 16'h2000;
        i_miss = 1'b1; i_miss_addr = 16'h0040;
        wait_ev(0, "t2_dtag");
        tick(); d_miss = 1'b0;
        wait_ev(1, "t2_itag");
        tick(); i_miss = 1'b0;
        tick();
        chk("t2_reads", rd_log.size(), 16);
        chk("t2_d_first", rd_log[0], 16'h2000);
        chk("t2_i_first", rd_log[8], 16'h0040);
        chk("t2_i_last", rd_log[15], 16'h004E);
        chk("t2_i_start", fb_i - tag_d, 2);

        // 3: store outranks pending I miss
        clear_logs();
        d_wr_req = 1'b1; d_wr_addr = 16'h3000; d_wr_data = 16'hBEEF;
        i_miss = 1'b1; i_miss_addr = 16'h0C80;
        wait_ev(2, "t3_ack");
        tick(); d_wr_req = 1'b0;
        wait_ev(1, "t3_itag");
        tick(); i_miss = 1'b0;
        tick();
        chk("t3_wr_addr", wr_addr, 16'h3000);
        chk("t3_wr_data", wr_data, 16'hBEEF);
        chk("t3_acks", ack_cnt, 1);
        chk("t3_i_start", fb_i - ack_cyc, 2);
        chk("t3_i_first", rd_log[0], 16'h0C80);

        // 4: two-cycle valid gap after word 3
        clear_logs();
        stall_at = delivered + 4;
        d_miss = 1'b1; d_miss_addr = 16'h5554;
        wait_ev(0, "t4_tag");
        tick(); d_miss = 1'b0;
        tick();
        chk("t4_busy_cycles", busy_d, 14);
        chk("t4_words", wd_d, 8);
        chk("t4_tag_cycle", tag_d - fb_d, 13);

        // 5: reset while word 5 arrives, stale valids, then refill
        d_miss = 1'b1; d_miss_addr = 16'h7008;
        wait_ev(3, "t5_word4");
        tick(); rst = 1'b1; d_miss = 1'b0;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_enable", mem_enable, 0);
        chk("t5_rst_busy", d_busy, 0);
        chk("t5_rst_word", fill_word, 0);
        repeat (6) tick();
        clear_logs();
        d_miss = 1'b1;
        wait_ev(0, "t5_tag");
        tick(); d_miss = 1'b0;
        tick();
        chk("t5_words", wd_d, 8);
        chk("t5_first_word", first_fw, 0);
        chk("t5_first_addr", rd_log[0], 16'h7000);

        // 6: I miss dropped after one cycle, then a stray valid in IDLE
        clear_logs();
        i_miss = 1'b1; i_miss_addr = 16'h0A12;
        tick(); i_miss = 1'b0;
        wait_ev(1, "t6_itag");
        tick();
        chk("t6_words", wd_i, 8);
        chk("t6_first_addr", rd_log[0], 16'h0A10);
        clear_logs();
        spur_at = cyc + 1;
        repeat (4) tick();
        chk("t6_spur_i", wd_i, 0);
        chk("t6_spur_d", wd_d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
